// File: rtl/pdm_arb_pkg.sv
// Shared constants and types for the PDM output arbiter.
// The port count is fixed at four in this revision; LEN_W sets the
// width of the per-packet byte counter (packets up to 31 bytes).
package pdm_arb_pkg;

  localparam int NUM_PORTS = 4;
  localparam int LEN_W     = 5;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT,
    XFER,
    GAPST
  } arb_state_t;

  typedef logic [1:0] port_idx_t;

  // Round-robin successor; the 2-bit index wraps port 4 back to port 1.
  function automatic port_idx_t next_port(input port_idx_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/pdm_out_arb_pick.sv
// Combinational round-robin search: returns the first pending port at or
// after the pointer, wrapping past port 4 back to port 1.
module pdm_rr_pick
  import pdm_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] pend,
  input  port_idx_t            ptr,
  output port_idx_t            gnt,
  output logic                 any
);

  port_idx_t idx;
  logic      found;

  // Walk the four candidates in rotated order and keep the first hit.
  always_comb begin
    gnt   = ptr;
    any   = |pend;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = ptr + port_idx_t'(i);
      if (!found && pend[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdm_out_arb.sv
// Round-robin scheduler for the four PDM output ports. Captures length
// announcements, issues one proceed pulse at a time and merges the granted
// port's payload onto a single registered byte stream with sop/eop/port tags.
// Optional per-port completed-packet counters: define PDM_ARB_STATS_EN.
module pdm_out_arb
  import pdm_arb_pkg::*;
#(
  parameter int DATA_DLY = 2,
  parameter int GAP      = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [LEN_W-1:0]  newdata_len_1,
  input  logic [LEN_W-1:0]  newdata_len_2,
  input  logic [LEN_W-1:0]  newdata_len_3,
  input  logic [LEN_W-1:0]  newdata_len_4,
  input  logic [DATA_W-1:0] data_out_1,
  input  logic [DATA_W-1:0] data_out_2,
  input  logic [DATA_W-1:0] data_out_3,
  input  logic [DATA_W-1:0] data_out_4,
  output logic              proceed_1,
  output logic              proceed_2,
  output logic              proceed_3,
  output logic              proceed_4,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [1:0]        pkt_port,
`ifdef PDM_ARB_STATS_EN
  output logic [15:0]       pkt_cnt_1,
  output logic [15:0]       pkt_cnt_2,
  output logic [15:0]       pkt_cnt_3,
  output logic [15:0]       pkt_cnt_4,
`endif
  output logic [NUM_PORTS-1:0] req_err
);

  // WAIT covers DATA_DLY-1 clocks; with DATA_DLY=1 the FSM goes straight to XFER.
  localparam logic [2:0] DLY_INIT = 3'(DATA_DLY - 1);
  localparam logic [1:0] GAP_INIT = 2'(GAP);

  arb_state_t               state;
  logic [NUM_PORTS-1:0]     pend;
  logic [LEN_W-1:0]         len_q [NUM_PORTS];
  logic [LEN_W-1:0]         len_in [NUM_PORTS];
  logic [DATA_W-1:0]        din [NUM_PORTS];
  logic [NUM_PORTS-1:0]     clr;
  logic [NUM_PORTS-1:0]     proceed_q;
  port_idx_t                rr;
  port_idx_t                gnt;
  port_idx_t                pick;
  logic                     pick_any;
  logic [LEN_W-1:0]         cnt;
  logic [2:0]               dly_cnt;
  logic [1:0]               gap_cnt;
  logic                     first;

  // Gather the per-port inputs into arrays and flag the port being granted.
  always_comb begin
    len_in[0] = newdata_len_1;
    len_in[1] = newdata_len_2;
    len_in[2] = newdata_len_3;
    len_in[3] = newdata_len_4;
    din[0]    = data_out_1;
    din[1]    = data_out_2;
    din[2]    = data_out_3;
    din[3]    = data_out_4;
    clr       = '0;
    if (state == GRANT) begin
      clr[gnt] = 1'b1;
    end
  end

  pdm_rr_pick u_pick (
    .pend (pend),
    .ptr  (rr),
    .gnt  (pick),
    .any  (pick_any)
  );

  // Latch requests; a repeat while still pending is flagged and ignored, except
  // on the grant edge where the new request wins over the clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pend    <= '0;
      req_err <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        len_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (len_in[p] != '0) begin
          if (pend[p] && !clr[p]) begin
            req_err[p] <= 1'b1;
          end else begin
            pend[p]  <= 1'b1;
            len_q[p] <= len_in[p];
          end
        end else if (clr[p]) begin
          pend[p] <= 1'b0;
        end
      end
    end
  end

  // Arbitration FSM with registered proceed and merged-stream outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      rr        <= '0;
      gnt       <= '0;
      cnt       <= '0;
      dly_cnt   <= '0;
      gap_cnt   <= '0;
      first     <= 1'b0;
      proceed_q <= '0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      pkt_sop   <= 1'b0;
      pkt_eop   <= 1'b0;
      pkt_port  <= '0;
    end else begin
      proceed_q <= '0;
      pkt_valid <= 1'b0;
      pkt_sop   <= 1'b0;
      pkt_eop   <= 1'b0;
      pkt_data  <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          proceed_q[gnt] <= 1'b1;
          cnt            <= len_q[gnt];
          rr             <= next_port(gnt);
          first          <= 1'b1;
          dly_cnt        <= DLY_INIT;
          state          <= (DATA_DLY > 1) ? WAIT : XFER;
        end
        WAIT: begin
          if (dly_cnt <= 3'd1) begin
            state <= XFER;
          end else begin
            dly_cnt <= dly_cnt - 3'd1;
          end
        end
        XFER: begin
          pkt_valid <= 1'b1;
          pkt_data  <= din[gnt];
          pkt_port  <= gnt;
          pkt_sop   <= first;
          pkt_eop   <= (cnt == 5'd1);
          first     <= 1'b0;
          cnt       <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            gap_cnt <= GAP_INIT;
            state   <= (GAP == 0) ? IDLE : GAPST;
          end
        end
        GAPST: begin
          if (gap_cnt <= 2'd1) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign proceed_1 = proceed_q[0];
  assign proceed_2 = proceed_q[1];
  assign proceed_3 = proceed_q[2];
  assign proceed_4 = proceed_q[3];

`ifdef PDM_ARB_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_PORTS];

  // Count completed packets per port on the eop byte; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        pkt_cnt_q[p] <= '0;
      end
    end else if (state == XFER && cnt == 5'd1) begin
      pkt_cnt_q[gnt] <= pkt_cnt_q[gnt] + 16'd1;
    end
  end

  assign pkt_cnt_1 = pkt_cnt_q[0];
  assign pkt_cnt_2 = pkt_cnt_q[1];
  assign pkt_cnt_3 = pkt_cnt_q[2];
  assign pkt_cnt_4 = pkt_cnt_q[3];
`endif

endmodule
